// File: rtl/clock_core.sv
// rtl/clock_core.sv - BCD time-of-day core with 1 s prescaler, N alarms, ring control and 12/24 h display
module clock_core #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int N_ALARM = 4,
   parameter int RING_S  = 10,
   localparam int AW     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [1:0]         field,
   input  logic               inc,
   input  logic               ack,
   input  logic [AW-1:0]      alarm_sel,
   input  logic [N_ALARM-1:0] alarm_en,
   input  logic               mode_12h,
   output logic [7:0]         hour,
   output logic [7:0]         minute,
   output logic [7:0]         second,
   output logic [7:0]         disp_hour,
   output logic               pm,
   output logic [7:0]         alarm_hour,
   output logic [7:0]         alarm_minute,
   output logic               tick_1s,
   output logic               ring,
   output logic [AW-1:0]      ring_id
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   localparam logic [1:0] MODE_SET_TIME  = 2'b01;
   localparam logic [1:0] MODE_SET_ALARM = 2'b10;

   localparam logic [1:0] FIELD_SEC   = 2'd0;
   localparam logic [1:0] FIELD_MIN   = 2'd1;
   localparam logic [1:0] FIELD_HOUR  = 2'd2;
   localparam logic [1:0] FIELD_CLEAR = 2'd3;

   // BCD increment modulo 60; tens digit wraps after 5
   function automatic logic [7:0] inc60(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] >= 4'd5) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // BCD increment modulo 24
   function automatic logic [7:0] inc24(input logic [7:0] v);
      logic [7:0] r;
      if (v >= 8'h23) begin
         r = 8'h00;
      end else if (v[3:0] >= 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   logic [PW-1:0] pre_cnt;
   logic          run_mode;
   logic          pre_wrap;
   logic [7:0]    ring_cnt;

   logic [7:0]    alarm_h [N_ALARM];
   logic [7:0]    alarm_m [N_ALARM];
   logic          sel_ok;

   logic [7:0]    nxt_sec;
   logic [7:0]    nxt_min;
   logic [7:0]    nxt_hour;
   logic          match_hit;
   logic [AW-1:0] match_id;

   logic [4:0]    hour_bin;
   logic [4:0]    hour12_bin;
   logic [7:0]    disp12;

   // Mode 11 behaves exactly like run mode
   assign run_mode = (mode[1] == mode[0]);
   assign pre_wrap = run_mode && (pre_cnt == PW'(CLK_HZ - 1));
   assign sel_ok   = (int'(alarm_sel) < N_ALARM);

   // 1 s prescaler: counts only while running, parked at 0 otherwise
   always_ff @(posedge clk) begin
      if (rst || !run_mode || pre_wrap) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   // Tick is registered alongside the time update so both appear in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_1s <= 1'b0;
      end else begin
         tick_1s <= pre_wrap;
      end
   end

   // Time value that the current second boundary would produce, with full carry
   always_comb begin
      nxt_sec  = inc60(second);
      nxt_min  = minute;
      nxt_hour = hour;
      if (second == 8'h59) begin
         nxt_min = inc60(minute);
         if (minute == 8'h59) begin
            nxt_hour = inc24(hour);
         end
      end
   end

   // Time-of-day register: carry chain on tick, independent field edits in set-time mode
   always_ff @(posedge clk) begin
      if (rst) begin
         hour   <= 8'h00;
         minute <= 8'h00;
         second <= 8'h00;
      end else if (pre_wrap) begin
         hour   <= nxt_hour;
         minute <= nxt_min;
         second <= nxt_sec;
      end else if (mode == MODE_SET_TIME && inc) begin
         case (field)
            FIELD_SEC:   second <= inc60(second);
            FIELD_MIN:   minute <= inc60(minute);
            FIELD_HOUR:  hour   <= inc24(hour);
            FIELD_CLEAR: second <= 8'h00;
            default:     second <= second;
         endcase
      end
   end

   // Alarm slot storage, edited one field at a time in set-alarm mode
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_ALARM; k++) begin
            alarm_h[k] <= 8'h00;
            alarm_m[k] <= 8'h00;
         end
      end else if (mode == MODE_SET_ALARM && inc && sel_ok) begin
         if (field == FIELD_MIN) begin
            alarm_m[alarm_sel] <= inc60(alarm_m[alarm_sel]);
         end else if (field == FIELD_HOUR) begin
            alarm_h[alarm_sel] <= inc24(alarm_h[alarm_sel]);
         end
      end
   end

   // Lowest enabled slot matching the upcoming hh:mm, only at the top of a minute
   always_comb begin
      match_hit = 1'b0;
      match_id  = '0;
      for (int k = N_ALARM - 1; k >= 0; k--) begin
         if (alarm_en[k] && alarm_h[k] == nxt_hour && alarm_m[k] == nxt_min) begin
            match_hit = 1'b1;
            match_id  = AW'(k);
         end
      end
      if (nxt_sec != 8'h00) begin
         match_hit = 1'b0;
      end
   end

   // Ring control: a match outranks ack; the counter only runs down on ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         ring     <= 1'b0;
         ring_id  <= '0;
         ring_cnt <= 8'd0;
      end else if (!run_mode) begin
         ring     <= 1'b0;
         ring_cnt <= 8'd0;
      end else if (pre_wrap && match_hit) begin
         ring     <= 1'b1;
         ring_id  <= match_id;
         ring_cnt <= 8'(RING_S);
      end else if (ack) begin
         ring     <= 1'b0;
         ring_cnt <= 8'd0;
      end else if (pre_wrap && ring) begin
         if (ring_cnt <= 8'd1) begin
            ring     <= 1'b0;
            ring_cnt <= 8'd0;
         end else begin
            ring_cnt <= ring_cnt - 8'd1;
         end
      end
   end

   // Alarm read-back of the selected slot; out-of-range selections read as zero
   always_comb begin
      alarm_hour   = 8'h00;
      alarm_minute = 8'h00;
      if (sel_ok) begin
         alarm_hour   = alarm_h[alarm_sel];
         alarm_minute = alarm_m[alarm_sel];
      end
   end

   // 12/24 h display: convert via binary so the PM offset is a plain subtraction
   always_comb begin
      hour_bin = ({1'b0, hour[7:4]} * 5'd10) + {1'b0, hour[3:0]};
      if (hour_bin == 5'd0) begin
         hour12_bin = 5'd12;
      end else if (hour_bin > 5'd12) begin
         hour12_bin = hour_bin - 5'd12;
      end else begin
         hour12_bin = hour_bin;
      end
      if (hour12_bin >= 5'd10) begin
         disp12 = {4'd1, 4'(hour12_bin - 5'd10)};
      end else begin
         disp12 = {4'd0, hour12_bin[3:0]};
      end
      pm        = (hour_bin >= 5'd12);
      disp_hour = mode_12h ? disp12 : hour;
   end

endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - directed scoreboard bench for clock_core
module tb_clock_core;

   localparam int CLK_HZ  = 4;
   localparam int N_ALARM = 4;
   localparam int RING_S  = 3;
   localparam int AW      = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         mode;
   logic [1:0]         field;
   logic               inc;
   logic               ack;
   logic [AW-1:0]      alarm_sel;
   logic [N_ALARM-1:0] alarm_en;
   logic               mode_12h;
   logic [7:0]         hour;
   logic [7:0]         minute;
   logic [7:0]         second;
   logic [7:0]         disp_hour;
   logic               pm;
   logic [7:0]         alarm_hour;
   logic [7:0]         alarm_minute;
   logic               tick_1s;
   logic               ring;
   logic [AW-1:0]      ring_id;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   clock_core #(
      .CLK_HZ  (CLK_HZ),
      .N_ALARM (N_ALARM),
      .RING_S  (RING_S)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .field        (field),
      .inc          (inc),
      .ack          (ack),
      .alarm_sel    (alarm_sel),
      .alarm_en     (alarm_en),
      .mode_12h     (mode_12h),
      .hour         (hour),
      .minute       (minute),
      .second       (second),
      .disp_hour    (disp_hour),
      .pm           (pm),
      .alarm_hour   (alarm_hour),
      .alarm_minute (alarm_minute),
      .tick_1s      (tick_1s),
      .ring         (ring),
      .ring_id      (ring_id)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed %0h expected an entry", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", t, obs, e);
         end
      end
   endtask

   task automatic pulse_inc(input logic [1:0] f, input int n);
      field = f;
      for (int i = 0; i < n; i++) begin
         inc = 1'b1;
         step(1);
         inc = 1'b0;
         step(1);
      end
   endtask

   task automatic set_clock(input int nh, input int nm, input int ns);
      pulse_inc(2'd3, 1);
      pulse_inc(2'd0, ns);
      pulse_inc(2'd2, nh);
      pulse_inc(2'd1, nm);
   endtask

   task automatic wait_tick(input string tag);
      int k;
      k = 0;
      step(1);
      while (tick_1s !== 1'b1 && k < 4 * CLK_HZ) begin
         step(1);
         k++;
      end
      expect_val(tag, 32'd1);
      chk({31'd0, tick_1s});
   endtask

   initial begin
      rst = 1'b1; mode = 2'b00; field = 2'd0; inc = 1'b0; ack = 1'b0;
      alarm_sel = '0; alarm_en = '0; mode_12h = 1'b0;
      step(2);

      expect_val("rst_time", 32'h000000);  chk({8'd0, hour, minute, second});
      expect_val("rst_tick", 32'd0);       chk({31'd0, tick_1s});
      expect_val("rst_ring", 32'd0);       chk({31'd0, ring});
      expect_val("rst_ring_id", 32'd0);    chk({30'd0, ring_id});
      expect_val("rst_disp", 32'h00);      chk({24'd0, disp_hour});
      expect_val("rst_pm", 32'd0);         chk({31'd0, pm});
      expect_val("rst_alarm", 32'h0000);   chk({16'd0, alarm_hour, alarm_minute});

      rst = 1'b0;
      step(CLK_HZ - 1);
      expect_val("pre_tick_low", 32'd0);   chk({31'd0, tick_1s});
      expect_val("pre_sec", 32'h00);       chk({24'd0, second});
      step(1);
      expect_val("first_tick", 32'd1);     chk({31'd0, tick_1s});
      expect_val("first_time", 32'h000001); chk({8'd0, hour, minute, second});
      expect_val("first_ring", 32'd0);     chk({31'd0, ring});

      mode = 2'b01;
      step(1);
      expect_val("tick_one_cycle", 32'd0); chk({31'd0, tick_1s});
      set_clock(23, 59, 58);
      expect_val("set_235958", 32'h235958); chk({8'd0, hour, minute, second});
      expect_val("pm_23", 32'd1);          chk({31'd0, pm});
      expect_val("disp24_23", 32'h23);     chk({24'd0, disp_hour});
      mode_12h = 1'b1;
      #1;
      expect_val("disp12_23", 32'h11);     chk({24'd0, disp_hour});
      mode_12h = 1'b0;

      mode = 2'b00;
      step(CLK_HZ - 1);
      expect_val("restart_no_tick", 32'd0); chk({31'd0, tick_1s});
      step(1);
      expect_val("tick_235959", 32'd1);    chk({31'd0, tick_1s});
      expect_val("time_235959", 32'h235959); chk({8'd0, hour, minute, second});
      step(CLK_HZ);
      expect_val("period_tick", 32'd1);    chk({31'd0, tick_1s});
      expect_val("time_rollover", 32'h000000); chk({8'd0, hour, minute, second});
      expect_val("pm_00", 32'd0);          chk({31'd0, pm});
      wait_tick("tick_000001");
      expect_val("time_000001", 32'h000001); chk({8'd0, hour, minute, second});
      mode_12h = 1'b1;
      #1;
      expect_val("disp12_00", 32'h12);     chk({24'd0, disp_hour});
      expect_val("pm12_00", 32'd0);        chk({31'd0, pm});

      mode = 2'b01;
      step(1);
      pulse_inc(2'd1, 45);
      expect_val("min_45", 32'h45);        chk({24'd0, minute});
      pulse_inc(2'd1, 30);
      expect_val("min_wrap_15", 32'h0015); chk({16'd0, hour, minute});
      pulse_inc(2'd3, 1);
      expect_val("sec_clear", 32'h00);     chk({24'd0, second});
      pulse_inc(2'd2, 12);
      expect_val("disp12_12", 32'h112);    chk({23'd0, pm, disp_hour});
      pulse_inc(2'd2, 1);
      expect_val("disp12_13", 32'h101);    chk({23'd0, pm, disp_hour});
      pulse_inc(2'd2, 11);
      expect_val("hour_wrap_00", 32'h001500); chk({8'd0, hour, minute, second});
      mode_12h = 1'b0;

      mode = 2'b10;
      alarm_sel = 2'd1;
      pulse_inc(2'd2, 7);
      alarm_sel = 2'd3;
      pulse_inc(2'd2, 7);
      pulse_inc(2'd0, 3);
      pulse_inc(2'd3, 2);
      expect_val("alarm3_rd", 32'h0700);   chk({16'd0, alarm_hour, alarm_minute});
      alarm_sel = 2'd2;
      #1;
      expect_val("alarm2_rd", 32'h0000);   chk({16'd0, alarm_hour, alarm_minute});
      expect_val("time_frozen", 32'h001500); chk({8'd0, hour, minute, second});
      alarm_sel = 2'd1;
      alarm_en = 4'b1010;

      mode = 2'b01;
      set_clock(6, 44, 59);
      expect_val("set_065959", 32'h065959); chk({8'd0, hour, minute, second});
      mode = 2'b00;
      step(1);
      expect_val("ring_idle", 32'd0);      chk({31'd0, ring});
      wait_tick("tick_alarm");
      expect_val("time_070000", 32'h070000); chk({8'd0, hour, minute, second});
      expect_val("ring_on", 32'h5);        chk({29'd0, ring, ring_id});
      wait_tick("tick_r1");
      wait_tick("tick_r2");
      expect_val("ring_hold", 32'd1);      chk({31'd0, ring});
      wait_tick("tick_r3");
      expect_val("ring_timeout", 32'd0);   chk({31'd0, ring});

      mode = 2'b01;
      set_clock(23, 59, 59);
      expect_val("set_ack1", 32'h065959);  chk({8'd0, hour, minute, second});
      mode = 2'b00;
      wait_tick("tick_ack1");
      expect_val("ring_ack_pre", 32'd1);   chk({31'd0, ring});
      step(1);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      expect_val("ring_acked", 32'd0);     chk({31'd0, ring});

      mode = 2'b01;
      set_clock(23, 59, 59);
      alarm_en = 4'b1000;
      mode = 2'b00;
      step(CLK_HZ - 1);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      expect_val("coinc_tick", 32'd1);     chk({31'd0, tick_1s});
      expect_val("coinc_ring", 32'h7);     chk({29'd0, ring, ring_id});

      mode = 2'b01;
      step(1);
      expect_val("mode_exit_ring", 32'd0); chk({31'd0, ring});

      alarm_sel = 2'd3;
      rst = 1'b1;
      inc = 1'b1;
      field = 2'd2;
      step(1);
      rst = 1'b0;
      inc = 1'b0;
      expect_val("midrst_time", 32'h000000); chk({8'd0, hour, minute, second});
      expect_val("midrst_alarm", 32'h0000);  chk({16'd0, alarm_hour, alarm_minute});
      expect_val("midrst_ring", 32'd0);      chk({29'd0, ring, ring_id});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
